// File: rtl/sm_top.sv
// sm_top: schoolMIPS single-cycle 32-bit MIPS subset CPU with clock divider and debug read port
module sm_clk_divider #(
  parameter int unsigned shift  = 16,
  parameter bit          bypass = 1'b0
) (
  input  logic       clkIn,
  input  logic       rst_n,
  input  logic [3:0] devide,
  input  logic       enable,
  output logic       clkOut
);
  logic [31:0] r_cntr;
  always_ff @(posedge clkIn or negedge rst_n)
    if (!rst_n) r_cntr <= '0;
    else if (enable) r_cntr <= r_cntr + 32'd1;
  assign clkOut = bypass ? clkIn : r_cntr[5'(shift + 32'(devide))];
endmodule

module sm_register_file (
  input  logic        clk,
  input  logic [4:0]  a0,
  input  logic [4:0]  a1,
  input  logic [4:0]  a2,
  input  logic [4:0]  a3,
  output logic [31:0] rd0,
  output logic [31:0] rd1,
  output logic [31:0] rd2,
  input  logic [31:0] wd3,
  input  logic        we3
);
  logic [31:0] rf [0:31];
  assign rd0 = (a0 == 5'd0) ? 32'd0 : rf[a0];
  assign rd1 = (a1 == 5'd0) ? 32'd0 : rf[a1];
  assign rd2 = (a2 == 5'd0) ? 32'd0 : rf[a2];
  always_ff @(posedge clk)
    if (we3 && a3 != 5'd0) rf[a3] <= wd3;
endmodule

module sm_cpu (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  regAddr,
  output logic [31:0] regData
);
  logic [31:0] r_pc;
  logic [31:0] instr;
  logic [31:0] rom [0:63];
  logic [5:0]  w_op, w_funct;
  logic [4:0]  w_rs, w_rt, w_rd, w_sa, w_wa;
  logic [31:0] w_rd0, w_rd1, w_rd2, w_wd, w_imm_sx;
  logic        w_we, w_branch;
  assign instr = rom[r_pc[5:0]];
  assign {w_op, w_rs, w_rt, w_rd, w_sa, w_funct} = instr;
  assign w_imm_sx = {{16{instr[15]}}, instr[15:0]};
  sm_register_file rf (
    .clk(clk),
    .a0(regAddr),
    .a1(w_rs),
    .a2(w_rt),
    .a3(w_wa),
    .rd0(w_rd0),
    .rd1(w_rd1),
    .rd2(w_rd2),
    .wd3(w_wd),
    .we3(w_we)
  );
  always_comb begin
    w_we = 1'b0;
    w_wa = w_rt;
    w_wd = '0;
    if (w_op == 6'b000000) begin
      w_wa = w_rd;
      w_we = 1'b1;
      case (w_funct)
        6'b100001: w_wd = w_rd1 + w_rd2;
        6'b100101: w_wd = w_rd1 | w_rd2;
        6'b000010: w_wd = w_rd2 >> w_sa;
        6'b101011: w_wd = {31'd0, w_rd1 < w_rd2};
        6'b100011: w_wd = w_rd1 - w_rd2;
        default:   w_we = 1'b0;
      endcase
    end else if (w_op == 6'b001001) begin
      w_we = 1'b1;
      w_wd = w_rd1 + w_imm_sx;
    end else if (w_op == 6'b001111) begin
      w_we = 1'b1;
      w_wd = {instr[15:0], 16'd0};
    end
  end
  assign w_branch = (w_op == 6'b000100 && w_rd1 == w_rd2) || (w_op == 6'b000101 && w_rd1 != w_rd2);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_pc <= '0;
    else r_pc <= r_pc + 32'd1 + (w_branch ? w_imm_sx : 32'd0);
  assign regData = (regAddr == 5'd0) ? r_pc : w_rd0;
endmodule

module sm_top #(
  parameter int unsigned shift  = 16,
  parameter bit          bypass = 1'b0
) (
  input  logic        clkIn,
  input  logic        rst_n,
  input  logic [3:0]  clkDevide,
  input  logic        clkEnable,
  output logic        clk,
  input  logic [4:0]  regAddr,
  output logic [31:0] regData
);
  sm_clk_divider #(.shift(shift), .bypass(bypass)) sm_clk_divider (
    .clkIn(clkIn),
    .rst_n(rst_n),
    .devide(clkDevide),
    .enable(clkEnable),
    .clkOut(clk)
  );
  sm_cpu sm_cpu (
    .clk(clk),
    .rst_n(rst_n),
    .regAddr(regAddr),
    .regData(regData)
  );
endmodule

// File: tb/tb_sm_top.sv
// tb_sm_top: instruction-level reference model vs. sm_top, plus directed divider checks
module tb_sm_top;
  logic        clkIn = 1'b0;
  logic        rst_n = 1'b0;
  logic [4:0]  regAddr = 5'd0;
  logic [31:0] regData;
  logic        clk1;
  logic        rst2 = 1'b0;
  logic        en2 = 1'b1;
  logic        clk2;
  logic [31:0] regData2;
  int          tests = 0;
  int          fails = 0;
  bit          cmp_en = 1'b0;
  logic [31:0] m_pc = 32'd0;
  logic [31:0] m_rf [0:31];
  logic [31:0] m_prog [0:63];
  logic [31:0] p [0:63];

  always #5 clkIn = ~clkIn;

  sm_top #(.shift(16), .bypass(1'b1)) dut (
    .clkIn(clkIn), .rst_n(rst_n), .clkDevide(4'd0), .clkEnable(1'b1),
    .clk(clk1), .regAddr(regAddr), .regData(regData)
  );
  sm_top #(.shift(0), .bypass(1'b0)) dut_div (
    .clkIn(clkIn), .rst_n(rst2), .clkDevide(4'd1), .clkEnable(en2),
    .clk(clk2), .regAddr(5'd0), .regData(regData2)
  );

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic put(input logic [4:0] r, input logic [31:0] v);
    if (r != 5'd0) m_rf[r] = v;
  endtask

  // one instruction of the ISA, straight from the instruction semantics
  task automatic step();
    logic [31:0] ins, a, b, sx, nxt;
    logic [5:0]  op, fn;
    logic [4:0]  rs, rt, rd, sa;
    ins = m_prog[m_pc[5:0]];
    {op, rs, rt, rd, sa, fn} = ins;
    a = m_rf[rs];
    b = m_rf[rt];
    sx = {{16{ins[15]}}, ins[15:0]};
    nxt = m_pc + 32'd1;
    if (op == 6'h00 && fn == 6'h21) put(rd, a + b);
    else if (op == 6'h00 && fn == 6'h25) put(rd, a | b);
    else if (op == 6'h00 && fn == 6'h02) put(rd, b >> sa);
    else if (op == 6'h00 && fn == 6'h2b) put(rd, (a < b) ? 32'd1 : 32'd0);
    else if (op == 6'h00 && fn == 6'h23) put(rd, a - b);
    else if (op == 6'h09) put(rt, a + sx);
    else if (op == 6'h0f) put(rt, {ins[15:0], 16'd0});
    else if (op == 6'h04 && a == b) nxt = nxt + sx;
    else if (op == 6'h05 && a != b) nxt = nxt + sx;
    m_pc = nxt;
  endtask

  always @(posedge clkIn) if (rst_n) step();

  initial forever begin
    @(negedge clkIn);
    #2;
    if (cmp_en) chk("regdata", regData, (regAddr == 5'd0) ? m_pc : m_rf[regAddr]);
  end

  task automatic start();
    @(negedge clkIn);
    for (int i = 0; i < 64; i++) begin
      dut.sm_cpu.rom[i] = 32'd0;
      m_prog[i] = 32'd0;
    end
    rst_n = 1'b0;
    m_pc = 32'd0;
    cmp_en = 1'b1;
    repeat (4) @(negedge clkIn);
    regAddr = 5'd0;
    #1 chk("rst_pc", regData, 32'd0);
    for (int i = 0; i < 64; i++) begin
      dut.sm_cpu.rom[i] = p[i];
      m_prog[i] = p[i];
    end
    rst_n = 1'b1;
  endtask

  task automatic run(input int n);
    repeat (n) @(negedge clkIn);
  endtask

  task automatic peek(input string nm, input logic [4:0] a, input logic [31:0] exp);
    regAddr = a;
    #1 chk(nm, regData, exp);
  endtask

  task automatic clear_p();
    for (int i = 0; i < 64; i++) p[i] = 32'd0;
  endtask

  function automatic logic [31:0] rnd_ins();
    logic [4:0]  rs, rt, rd, sa;
    logic [15:0] imm, off;
    rs = 5'($urandom_range(0, 7));
    rt = 5'($urandom_range(0, 7));
    rd = 5'($urandom_range(0, 7));
    sa = 5'($urandom);
    imm = 16'($urandom);
    off = 16'($urandom_range(0, 8)) - 16'd4;
    case ($urandom_range(0, 11))
      0:  return {6'h00, rs, rt, rd, 5'd0, 6'h21};
      1:  return {6'h00, rs, rt, rd, 5'd0, 6'h25};
      2:  return {6'h00, 5'd0, rt, rd, sa, 6'h02};
      3:  return {6'h00, rs, rt, rd, 5'd0, 6'h2b};
      4:  return {6'h00, rs, rt, rd, 5'd0, 6'h23};
      5:  return {6'h09, rs, rt, imm};
      6:  return {6'h0f, 5'd0, rt, imm};
      7:  return {6'h04, rs, rt, off};
      8:  return {6'h05, rs, rt, off};
      9:  return {6'h23, rs, rt, imm};
      10: return {6'h00, rs, rt, rd, 5'd0, 6'h20};
      default: return 32'd0;
    endcase
  endfunction

  initial begin
    for (int i = 0; i < 32; i++) begin
      dut.sm_cpu.rf.rf[i] = 32'd0;
      dut_div.sm_cpu.rf.rf[i] = 32'd0;
      m_rf[i] = 32'd0;
    end
    #1;
    for (int i = 0; i < 64; i++) dut_div.sm_cpu.rom[i] = 32'd0;
    // PC counts up from 0 after reset release
    clear_p();
    start();
    chk("bypass_clk", {31'd0, clk1}, {31'd0, clkIn});
    run(1); peek("pc1", 5'd0, 32'd1);
    run(1); peek("pc2", 5'd0, 32'd2);
    run(1); peek("pc3", 5'd0, 32'd3);
    // addiu/addu/subu
    clear_p();
    p[0] = 32'h24020005; p[1] = 32'h24030003; p[2] = 32'h00431021; p[3] = 32'h00431023;
    start();
    run(1); peek("addiu_v0", 5'd2, 32'd5);
    run(2); peek("addu_v0", 5'd2, 32'd8);
    run(1); peek("subu_v0", 5'd2, 32'd5);
    // lui/or/srl/sltu
    clear_p();
    p[0] = 32'h24030003; p[1] = 32'h3C021234; p[2] = 32'h00431025; p[3] = 32'h00021402; p[4] = 32'h0062202B;
    start();
    run(3); peek("lui_or", 5'd2, 32'h12340003);
    run(1); peek("srl", 5'd2, 32'h00001234);
    run(1); peek("sltu", 5'd4, 32'd1);
    // bne loop runs three times then falls through
    clear_p();
    p[0] = 32'h24010003; p[1] = 32'h2421FFFF; p[2] = 32'h1420FFFE;
    start();
    run(3); peek("loop_pc_back", 5'd0, 32'd1);
    run(4); peek("loop_pc_exit", 5'd0, 32'd3); peek("loop_r1", 5'd1, 32'd0);
    // $0 is immutable; beq self-loop pins the PC
    clear_p();
    p[0] = 32'h24050009; p[1] = 32'h24000007; p[2] = 32'h00002821; p[3] = 32'h1000FFFF;
    start();
    run(1); peek("r5_set", 5'd5, 32'd9);
    run(2); peek("r0_zero", 5'd5, 32'd0);
    run(1); peek("selfloop_a", 5'd0, 32'd3);
    run(5); peek("selfloop_b", 5'd0, 32'd3);
    // random programs with an asynchronous mid-run reset
    for (int t = 0; t < 4; t++) begin
      for (int i = 0; i < 64; i++) p[i] = rnd_ins();
      start();
      for (int c = 0; c < 250; c++) begin
        @(negedge clkIn);
        regAddr = 5'($urandom_range(0, 7));
        if (c == 120) begin
          @(posedge clkIn);
          #1 rst_n = 1'b0;
          m_pc = 32'd0;
          regAddr = 5'd0;
          #1 chk("async_rst_pc", regData, 32'd0);
          #1 rst_n = 1'b1;
        end
      end
    end
    cmp_en = 1'b0;
    // divider: shift 0, clkDevide 1 -> clk = cnt[1], period 4 clkIn
    @(posedge clkIn);
    #2 rst2 = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      @(posedge clkIn);
      #1;
      chk("div_clk", {31'd0, clk2}, 32'((k >> 1) & 1));
      chk("div_pc", regData2, 32'((k + 2) / 4));
    end
    en2 = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clkIn);
      #1;
      chk("frozen_clk", {31'd0, clk2}, 32'd0);
      chk("frozen_pc", regData2, 32'd4);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
